spi_sck_gen: RTL and testbench

- Parametrised SPI serial-clock generator; successor to the fixed divide-by-6 SPI clock divider.
- Produces a burst of exactly N SCK periods with programmable half-period, selectable idle polarity (CPOL) and leading/trailing edge strobes for the shift datapath.
- Sits between the SPI master control FSM (start/abort/done handshake) and the shift register (edge strobes).

---
 rtl/spi_sck_gen_pkg.sv | 7 +
 rtl/spi_sck_gen.sv | 109 ++++++++++
 tb/tb_spi_sck_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spi_sck_gen_pkg.sv
// spi_pkg: shared state encoding and default sizes for the SPI serial-clock generator
package spi_pkg;
   typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;
   localparam int SPI_CNT_W  = 8;
   localparam int SPI_BITS_W = 5;
   localparam int DEF_HALF   = 2;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: burst of nbits SCK periods with programmable half-period, CPOL and edge strobes
module spi_sck_gen
   import spi_pkg::*;
#(
   parameter int CNT_W  = SPI_CNT_W,
   parameter int BITS_W = SPI_BITS_W
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  half_div,
   input  logic [BITS_W-1:0] nbits,
   input  logic              cpol,
   output logic              spi_clk,
   output logic              lead_stb,
   output logic              trail_stb,
   output logic              busy,
   output logic              done
);
   state_t state, state_n;
   logic [CNT_W-1:0] cyc_cnt, cyc_n, half_q, half_n;
   logic [BITS_W-1:0] bit_cnt, bit_n, nbits_q, nbits_n;
   logic cpol_q, cpol_n, sck_n, lead_n, trail_n, done_n, half_end;
   assign half_end = cyc_cnt == half_q;
   assign busy = state != IDLE;
   always_comb begin
      state_n = state;
      cyc_n   = cyc_cnt;
      bit_n   = bit_cnt;
      half_n  = half_q;
      nbits_n = nbits_q;
      cpol_n  = cpol_q;
      sck_n   = spi_clk;
      lead_n  = 1'b0;
      trail_n = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            sck_n = cpol;
            if (start && !abort && nbits != '0) begin
               state_n = LEAD;
               half_n  = half_div;
               nbits_n = nbits;
               cpol_n  = cpol;
               cyc_n   = '0;
               bit_n   = '0;
               sck_n   = ~cpol;
               lead_n  = 1'b1;
            end
         end
         LEAD: begin
            if (abort) begin
               state_n = IDLE;
               sck_n   = cpol_q;
            end else if (half_end) begin
               state_n = TRAIL;
               sck_n   = cpol_q;
               trail_n = 1'b1;
               bit_n   = bit_cnt + 1'b1;
               cyc_n   = '0;
            end else
               cyc_n = cyc_cnt + 1'b1;
         end
         TRAIL: begin
            if (abort) begin
               state_n = IDLE;
               sck_n   = cpol_q;
            end else if (half_end && bit_cnt == nbits_q) begin
               state_n = IDLE;
               done_n  = 1'b1;
               cyc_n   = '0;
            end else if (half_end) begin
               state_n = LEAD;
               sck_n   = ~cpol_q;
               lead_n  = 1'b1;
               cyc_n   = '0;
            end else
               cyc_n = cyc_cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state     <= IDLE;
         cyc_cnt   <= '0;
         bit_cnt   <= '0;
         half_q    <= '0;
         nbits_q   <= '0;
         cpol_q    <= 1'b0;
         spi_clk   <= 1'b0;
         lead_stb  <= 1'b0;
         trail_stb <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cyc_cnt   <= cyc_n;
         bit_cnt   <= bit_n;
         half_q    <= half_n;
         nbits_q   <= nbits_n;
         cpol_q    <= cpol_n;
         spi_clk   <= sck_n;
         lead_stb  <= lead_n;
         trail_stb <= trail_n;
         done      <= done_n;
      end
   end
endmodule

// File: tb/tb_spi_sck_gen.sv
// tb_spi_sck_gen: vector table, hand sequences and random traffic against a time-based burst model
module tb_spi_sck_gen;
   localparam int CNT_W  = 8;
   localparam int BITS_W = 5;
   logic clk = 1'b0;
   logic n_reset, start, abort, cpol;
   logic [CNT_W-1:0] half_div;
   logic [BITS_W-1:0] nbits;
   logic spi_clk, lead_stb, trail_stb, busy, done;
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   spi_sck_gen #(.CNT_W(CNT_W), .BITS_W(BITS_W)) dut (
      .clk(clk), .n_reset(n_reset), .start(start), .abort(abort), .half_div(half_div),
      .nbits(nbits), .cpol(cpol), .spi_clk(spi_clk), .lead_stb(lead_stb),
      .trail_stb(trail_stb), .busy(busy), .done(done)
   );
   bit m_act = 0;
   int m_t = 0, m_h = 0, m_n = 0;
   bit m_cpol = 0;
   logic [4:0] exp_o = '0;
   function automatic logic [4:0] phase(input int t, input int h, input bit c);
      int ph;
      ph = t % (2 * (h + 1));
      return {ph <= h ? ~c : c, ph == 0, ph == h + 1, 1'b1, 1'b0};
   endfunction
   // Expected outputs derive from elapsed time within the burst, not from a state machine
   always @(posedge clk) begin : model
      int t;
      t = m_t + 1;
      if (!n_reset) begin
         m_act <= 0;
         exp_o <= '0;
      end else if (m_act && abort) begin
         m_act <= 0;
         exp_o <= {m_cpol, 4'b0000};
      end else if (m_act && t == m_n * 2 * (m_h + 1)) begin
         m_act <= 0;
         exp_o <= {m_cpol, 4'b0001};
      end else if (m_act) begin
         m_t   <= t;
         exp_o <= phase(t, m_h, m_cpol);
      end else if (start && !abort && nbits != 0) begin
         m_act  <= 1;
         m_t    <= 0;
         m_h    <= int'(half_div);
         m_n    <= int'(nbits);
         m_cpol <= cpol;
         exp_o  <= phase(0, int'(half_div), cpol);
      end else
         exp_o <= {cpol, 4'b0000};
   end
   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask
   task automatic step();
      @(negedge clk);
      n_chk++;
      if ({spi_clk, lead_stb, trail_stb, busy, done} !== exp_o) begin
         n_fail++;
         $display("FAIL outputs at %0t: got clk/lead/trail/busy/done=%b expected %b",
                  $time, {spi_clk, lead_stb, trail_stb, busy, done}, exp_o);
      end
   endtask
   typedef struct {
      int half, nb, pol, abort_tr, noise, lat, leads, trails;
   } vec_t;
   vec_t vecs[6];
   task automatic run_vec(input vec_t v);
      int lat, lc, tc, dc, ab;
      half_div = CNT_W'(v.half);
      nbits    = BITS_W'(v.nb);
      cpol     = v.pol[0];
      start    = 1;
      abort    = 0;
      step();
      start = 0;
      chk("first_lead", lead_stb, 1);
      lat = 0; lc = int'(lead_stb); tc = 0; dc = 0; ab = -1;
      while (lat < 20000) begin
         if (ab < 0 && v.abort_tr != 0 && tc == v.abort_tr) begin
            abort = 1;
            start = 0;
            ab    = lat;
         end else begin
            abort = 0;
            if (v.noise != 0 && ab < 0) begin
               start    = $urandom_range(1);
               half_div = CNT_W'($urandom);
               nbits    = BITS_W'($urandom);
               cpol     = $urandom_range(1);
            end
         end
         step();
         lat++;
         lc += int'(lead_stb);
         tc += int'(trail_stb);
         dc += int'(done);
         if (ab >= 0 && lat == ab + 1) begin
            chk("abort_busy", busy, 0);
            chk("abort_level", spi_clk, v.pol);
         end
         if (done || (ab >= 0 && lat > ab + 40)) break;
      end
      start = 0; abort = 0;
      half_div = CNT_W'(v.half); nbits = BITS_W'(v.nb); cpol = v.pol[0];
      if (v.lat != 0) chk("done_latency", lat, v.lat);
      else chk("no_done", dc, 0);
      chk("lead_count", lc, v.leads);
      chk("trail_count", tc, v.trails);
      step();
      chk("idle_level", spi_clk, v.pol);
   endtask
   initial begin
      vecs[0] = '{2,   3,  0, 0, 0, 18,    3,  3};
      vecs[1] = '{0,   4,  1, 0, 0, 8,     4,  4};
      vecs[2] = '{4,   8,  0, 2, 0, 0,     2,  2};
      vecs[3] = '{5,   2,  1, 0, 1, 24,    2,  2};
      vecs[4] = '{255, 31, 0, 0, 0, 15872, 31, 31};
      vecs[5] = '{0,   1,  0, 0, 0, 2,     1,  1};
      n_reset = 0; start = 0; abort = 0; cpol = 0; half_div = '0; nbits = '0;
      repeat (2) step();
      chk("reset_clk", spi_clk, 0);
      chk("reset_busy", busy, 0);
      n_reset = 1;
      step();
      foreach (vecs[i]) run_vec(vecs[i]);
      nbits = '0; start = 1;
      repeat (3) begin
         step();
         chk("nbits0_busy", busy, 0);
         chk("nbits0_done", done, 0);
      end
      nbits = 5'd3; abort = 1;
      step();
      chk("abort_wins_idle", busy, 0);
      start = 0;
      step();
      chk("abort_idle_noop", busy, 0);
      abort = 0; half_div = 8'd3; nbits = 5'd5; start = 1;
      step();
      start = 0;
      repeat (2) step();
      n_reset = 0;
      step();
      chk("midreset_clk", spi_clk, 0);
      chk("midreset_busy", busy, 0);
      chk("midreset_done", done, 0);
      n_reset = 1;
      run_vec(vecs[0]);
      for (int c = 0; c < 3000; c++) begin
         n_reset  = ($urandom_range(299) != 0);
         start    = ($urandom_range(7) == 0);
         abort    = ($urandom_range(15) == 0);
         half_div = CNT_W'($urandom_range(3));
         nbits    = BITS_W'($urandom_range(5));
         cpol     = $urandom_range(1);
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
